// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and its divider sequencer.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // M-stage result is newer than W-stage, so it wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       reg_write_m,
        input logic [4:0] rd_w,
        input logic       reg_write_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
            sel = FWD_MEM;
        else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_div_sequencer.sv
// Iterative-divider sequencer: IDLE/RUN/DONE with a down-counter.
// Outputs are combinational from state and inputs so the start pulse lands in the request cycle.
module div_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic div_req_e,
    input  logic pc_src_e,
    output logic busy,
    output logic div_start,
    output logic div_accept
);

    localparam int CNT_BITS = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

    div_state_t          state_reg;
    logic [CNT_BITS-1:0] cnt_reg;

    // A redirecting branch kills the divide in E, so it must not start.
    always_comb begin
        busy       = rst_n && (state_reg == RUN);
        div_start  = rst_n && (state_reg == IDLE) && div_req_e && !pc_src_e;
        div_accept = rst_n && (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (div_req_e && !pc_src_e) begin
                        state_reg <= RUN;
                        cnt_reg   <= CNT_BITS'(DIV_LAT - 1);
                    end
                end
                RUN: begin
                    if (cnt_reg == '0)
                        state_reg <= DONE;
                    else
                        cnt_reg <= cnt_reg - 1'b1;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: forwarding, load-use stall, branch flush, divider freeze.
// Define HAZARD_PERF_CNT_EN to add saturating stall_cycles / flush_count performance counters.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_LAT = 32
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic [1:0] res_src_e,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       pc_src_e,
    input  logic       div_req_e,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       div_start,
    output logic       div_accept
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    logic [4:0] rs_e [2];
    logic [1:0] fwd  [2];
    logic       busy;
    logic       freeze;
    logic       lw_stall;

    assign rs_e[0] = rs1_e;
    assign rs_e[1] = rs2_e;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd[gi] = fwd_sel(rs_e[gi], rd_m, reg_write_m, rd_w, reg_write_w);
        end
    endgenerate

    assign forward_a_e = fwd[0];
    assign forward_b_e = fwd[1];

    div_sequencer #(
        .DIV_LAT (DIV_LAT)
    ) u_div_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_req_e  (div_req_e),
        .pc_src_e   (pc_src_e),
        .busy       (busy),
        .div_start  (div_start),
        .div_accept (div_accept)
    );

    assign lw_stall = (res_src_e == RES_LOAD) && (rd_e != 5'd0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    // The start cycle already counts toward divider latency, so it freezes like RUN.
    assign freeze = busy || div_start;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_m = 1'b1;
        if (rst_n) begin
            flush_m = freeze;
            if (freeze) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_d = 1'b0;
                flush_e = 1'b0;
            end else begin
                stall_f = lw_stall && !pc_src_e;
                stall_d = lw_stall && !pc_src_e;
                flush_d = pc_src_e;
                flush_e = lw_stall || pc_src_e;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_reg;
    logic [CNT_W-1:0] flush_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (stall_f && !(&stall_cycles_reg))
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            if (flush_e && !(&flush_count_reg))
                flush_count_reg <= flush_count_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with DIV_LAT=4: stimulus pushes expected vectors, a monitor pops and compares.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] res_src_e;
    logic       reg_write_m, reg_write_w, pc_src_e, div_req_e;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_start, div_accept;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
    int unsigned model_stalls = 0;
    int unsigned model_flushes = 0;
`endif

    hazard_ctrl #(.DIV_LAT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .res_src_e   (res_src_e),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .pc_src_e    (pc_src_e),
        .div_req_e   (div_req_e),
        .forward_a_e (forward_a_e),
        .forward_b_e (forward_b_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .stall_e     (stall_e),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .flush_m     (flush_m),
        .div_start   (div_start),
        .div_accept  (div_accept)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [11:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Vector layout: {fwd_a[1:0], fwd_b[1:0], stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_start, div_accept}
    localparam logic [11:0] V_RST   = 12'b00_00_000_111_00;
    localparam logic [11:0] V_ZERO  = 12'b00_00_000_000_00;
    localparam logic [11:0] V_LW    = 12'b00_00_110_010_00;
    localparam logic [11:0] V_BR    = 12'b00_00_000_110_00;
    localparam logic [11:0] V_START = 12'b00_00_111_001_10;
    localparam logic [11:0] V_RUN   = 12'b00_00_111_001_00;
    localparam logic [11:0] V_ACC   = 12'b00_00_000_000_01;

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
        rd_e = 0; rd_m = 0; rd_w = 0; res_src_e = 2'b00;
        reg_write_m = 0; reg_write_w = 0; pc_src_e = 0; div_req_e = 0;
    endtask

    // Inputs are already set by the caller; this launches one cycle and records its expectation.
    task automatic apply(input string name, input logic [11:0] vec);
        exp_t e;
        e.name = name;
        e.rst  = !rst_n;
        e.vec  = vec;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are combinational, so sample mid low phase of the cycle just driven.
    always @(negedge clk) begin
        exp_t e;
        logic [11:0] got;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
                   flush_d, flush_e, flush_m, div_start, div_accept};
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL %s got=%b want=%b", e.name, got, e.vec);
            end else begin
                $display("ok   %s got=%b", e.name, got);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (e.rst) begin
                model_stalls = 0;
                model_flushes = 0;
            end else begin
                total++;
                if (stall_cycles !== model_stalls || flush_count !== model_flushes) begin
                    bad++;
                    $display("FAIL %s_perf got=%0d/%0d want=%0d/%0d", e.name,
                             stall_cycles, flush_count, model_stalls, model_flushes);
                end
                if (e.vec[7]) model_stalls++;
                if (e.vec[3]) model_flushes++;
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        @(negedge clk);

        rst_n = 1'b0;
        apply("reset0", V_RST);
        apply("reset1", V_RST);
        rst_n = 1'b1;
        apply("idle", V_ZERO);

        rd_m = 5; reg_write_m = 1; rs1_e = 5; rd_w = 5; reg_write_w = 1;
        apply("fwd_a_mem_wins", 12'b10_00_000_000_00);
        rd_m = 0;
        apply("fwd_a_wb", 12'b01_00_000_000_00);
        clear_inputs();
        rd_w = 0; reg_write_w = 1; rs2_e = 0;
        apply("fwd_b_x0", V_ZERO);
        rs2_e = 3; rd_w = 3; reg_write_w = 0;
        apply("fwd_b_nowrite", V_ZERO);
        rd_m = 3; reg_write_m = 1;
        apply("fwd_b_mem", 12'b00_10_000_000_00);
        reg_write_m = 0; reg_write_w = 1;
        apply("fwd_b_wb", 12'b00_01_000_000_00);

        clear_inputs();
        res_src_e = 2'b01; rd_e = 7; rs2_d = 7;
        apply("lw_stall", V_LW);
        rd_e = 0; rs2_d = 0;
        apply("lw_rd0", V_ZERO);
        res_src_e = 2'b00; rd_e = 7; rs2_d = 7;
        apply("alu_no_stall", V_ZERO);
        res_src_e = 2'b01; rs2_d = 0; rs1_d = 7; pc_src_e = 1;
        apply("branch_over_lw", V_BR);
        clear_inputs();
        pc_src_e = 1; div_req_e = 1;
        apply("branch_kills_div", V_BR);

        clear_inputs();
        div_req_e = 1;
        apply("div_start", V_START);
        apply("div_run1", V_RUN);
        res_src_e = 2'b01; rd_e = 7; rs1_d = 7; pc_src_e = 1;
        apply("div_run2_ignore", V_RUN);
        res_src_e = 2'b00; rd_e = 0; rs1_d = 0; pc_src_e = 0;
        apply("div_run3", V_RUN);
        apply("div_run4", V_RUN);
        apply("div_accept", V_ACC);
        apply("div_b2b_start", V_START);
        apply("div_b2b_run1", V_RUN);
        apply("div_b2b_run2", V_RUN);
        rst_n = 1'b0;
        apply("div_reset", V_RST);
        rst_n = 1'b1;
        div_req_e = 0;
        for (int i = 0; i < 6; i++)
            apply($sformatf("after_abort%0d", i), V_ZERO);

        repeat (4) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
